instr_fetch_unit: RTL and testbench

//  Producer end of the instruction interface that feeds the control/ALU decode logic.

---
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds the PC, reads one word per fetch from a
// synchronous instruction RAM and presents it to decode over valid/ready.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          DATA_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        rd_issue      = 1'b0;
        case (state_q)
            FETCH: begin
                // Redirect wins over halt and suppresses the read entirely.
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (!halt) begin
                    rd_issue = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else begin
                    instr_d       = mem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_target;
                    state_d       = FETCH;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc_q + ADDR_W'(1);
                    state_d       = FETCH;
                end
            end
            default: begin
                instr_valid_d = 1'b0;
                state_d       = FETCH;
            end
        endcase
    end

    // State is already FETCH during reset; gate so no read leaks out then.
    assign mem_rd_en   = rd_issue & rst_n;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous RAM model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt;

    logic [15:0] ram [0:65535];
    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_pc(instr_pc),
        .redirect(redirect), .redirect_target(redirect_target), .halt(halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] w, input logic [15:0] pc);
        chk({tag, "_valid"}, instr_valid, 1);
        chk({tag, "_instr"}, instr, w);
        chk({tag, "_pc"}, instr_pc, pc);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[0]      = 16'h5A01;
        ram[1]      = 16'h0F23;
        ram[2]      = 16'hD105;
        ram[3]      = 16'h1111;
        ram[16'h40] = 16'hABCD;
        ram[16'h41] = 16'h1234;
        ram[16'hFFFF] = 16'hBEEF;
        mem_rdata = 16'h0;
        rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
        redirect_target = 16'h0; halt = 1'b0;

        // Reset state
        tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_rden", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);

        // Streaming with ready held high, one word every 3 cycles
        rst_n = 1'b1;
        #1;
        chk("t1_rden0", mem_rd_en, 1);
        tick();
        chk("t1_wait_valid", instr_valid, 0);
        chk("t1_wait_rden", mem_rd_en, 0);
        tick();
        expect_word("t1_w0", 16'h5A01, 16'h0000);
        tick(); tick(); tick();
        expect_word("t1_w1", 16'h0F23, 16'h0001);
        tick(); tick(); tick();
        expect_word("t1_w2", 16'hD105, 16'h0002);

        // Backpressure holds the word
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_word("t2_hold", 16'hD105, 16'h0002);
            chk("t2_hold_rden", mem_rd_en, 0);
        end
        instr_ready = 1'b1;
        tick();
        chk("t2_acc_valid", instr_valid, 0);
        chk("t2_acc_addr", mem_addr, 16'h0003);

        // Redirect during WAIT drops the returning word
        tick();
        redirect = 1'b1; redirect_target = 16'h0040;
        #1;
        chk("t3_wait_rden", mem_rd_en, 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("t3_redir_valid", instr_valid, 0);
        chk("t3_redir_addr", mem_addr, 16'h0040);
        chk("t3_redir_rden", mem_rd_en, 1);
        tick(); tick();
        expect_word("t3_tgt", 16'hABCD, 16'h0040);

        // Redirect beats ready in VALID
        redirect = 1'b1; redirect_target = 16'h0100;
        tick();
        redirect = 1'b0;
        #1;
        chk("t3_prio_valid", instr_valid, 0);
        chk("t3_prio_addr", mem_addr, 16'h0100);

        // Redirect plus halt in FETCH: redirect taken, no read
        redirect = 1'b1; halt = 1'b1; redirect_target = 16'hFFFF;
        #1;
        chk("t3_rh_rden", mem_rd_en, 0);
        tick();
        redirect = 1'b0; halt = 1'b0;
        #1;
        chk("t3_rh_addr", mem_addr, 16'hFFFF);

        // PC wrap
        tick(); tick();
        expect_word("t4_top", 16'hBEEF, 16'hFFFF);
        tick();
        chk("t4_wrap_addr", mem_addr, 16'h0000);

        // Halt in FETCH blocks the read
        halt = 1'b1;
        #1;
        chk("t4_halt_rden", mem_rd_en, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_halt_rden_n", mem_rd_en, 0);
            chk("t4_halt_valid", instr_valid, 0);
            chk("t4_halt_addr", mem_addr, 16'h0000);
        end
        halt = 1'b0;
        #1;
        chk("t4_unhalt_rden", mem_rd_en, 1);
        tick();
        halt = 1'b1;   // no effect once the fetch is in flight
        tick();
        expect_word("t4_inflight", 16'h5A01, 16'h0000);
        tick();
        chk("t4_halt_next_rden", mem_rd_en, 0);
        chk("t4_halt_next_addr", mem_addr, 16'h0001);
        halt = 1'b0;

        // Reset during WAIT
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_wrst_valid", instr_valid, 0);
        chk("t5_wrst_rden", mem_rd_en, 0);
        chk("t5_wrst_addr", mem_addr, 16'h0000);
        tick();
        rst_n = 1'b1;
        instr_ready = 1'b0;
        tick(); tick();
        expect_word("t5_after_wait", 16'h5A01, 16'h0000);

        // Reset during VALID, released mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_vrst_valid", instr_valid, 0);
        chk("t5_vrst_instr", instr, 0);
        rst_n = 1'b1;
        #1;
        chk("t5_vrst_addr", mem_addr, 16'h0000);
        chk("t5_vrst_rden", mem_rd_en, 1);
        begin
            int n = 0;
            while (!instr_valid && n < 10) begin
                tick();
                n++;
            end
            chk("t5_restart_timeout", (n < 10), 1);
            expect_word("t5_restart", 16'h5A01, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
